// File: rtl/tnoc_error_responder.sv
// Default-target endpoint: swallows requests that decode to no slave and answers
// reads and non-posted writes with DECODE_ERROR response packets.
module tnoc_error_responder #(
    parameter int                    ID_X_WIDTH         = 5,
    parameter int                    ID_Y_WIDTH         = 5,
    parameter int                    TAG_WIDTH          = 8,
    parameter int                    BURST_LENGTH_WIDTH = 8,
    parameter int                    DATA_WIDTH         = 256,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA         = '1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [ID_X_WIDTH-1:0]         i_id_x,
    input  logic [ID_Y_WIDTH-1:0]         i_id_y,
    input  logic                          i_request_valid,
    output logic                          o_request_ready,
    input  logic                          i_request_head,
    input  logic                          i_request_tail,
    input  logic [1:0]                    i_request_type,
    input  logic [ID_X_WIDTH-1:0]         i_request_source_x,
    input  logic [ID_Y_WIDTH-1:0]         i_request_source_y,
    input  logic [TAG_WIDTH-1:0]          i_request_tag,
    input  logic [BURST_LENGTH_WIDTH-1:0] i_request_burst_length,
    output logic                          o_response_valid,
    input  logic                          i_response_ready,
    output logic                          o_response_head,
    output logic                          o_response_tail,
    output logic                          o_response_type,
    output logic [ID_X_WIDTH-1:0]         o_response_destination_x,
    output logic [ID_Y_WIDTH-1:0]         o_response_destination_y,
    output logic [ID_X_WIDTH-1:0]         o_response_source_x,
    output logic [ID_Y_WIDTH-1:0]         o_response_source_y,
    output logic [TAG_WIDTH-1:0]          o_response_tag,
    output logic [1:0]                    o_response_status,
    output logic [DATA_WIDTH-1:0]         o_response_data
);

    localparam logic [1:0] TYPE_READ           = 2'b00;
    localparam logic [1:0] TYPE_WRITE          = 2'b01;
    localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;
    localparam logic [BURST_LENGTH_WIDTH:0] BEAT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RESPOND,
        DATA
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  head;
        logic                  tail;
        logic                  rtype;
        logic [ID_X_WIDTH-1:0] dst_x;
        logic [ID_Y_WIDTH-1:0] dst_y;
        logic [ID_X_WIDTH-1:0] src_x;
        logic [ID_Y_WIDTH-1:0] src_y;
        logic [TAG_WIDTH-1:0]  tag;
        logic [1:0]            status;
        logic [DATA_WIDTH-1:0] data;
    } response_t;

    state_e                        state_q, state_d;
    logic [1:0]                    type_q, type_d;
    logic [ID_X_WIDTH-1:0]         src_x_q, src_x_d;
    logic [ID_Y_WIDTH-1:0]         src_y_q, src_y_d;
    logic [TAG_WIDTH-1:0]          tag_q, tag_d;
    logic [BURST_LENGTH_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_LENGTH_WIDTH:0]   beat_q, beat_d;
    response_t                     resp_q, resp_d;

    logic                          request_ack;
    logic                          response_ack;
    logic                          finish_request;
    logic                          last_beat;
    logic [BURST_LENGTH_WIDTH:0]   beat_next;
    logic [1:0]                    eff_type;
    logic [ID_X_WIDTH-1:0]         eff_src_x;
    logic [ID_Y_WIDTH-1:0]         eff_src_y;
    logic [TAG_WIDTH-1:0]          eff_tag;

    assign o_request_ready = (state_q == IDLE) || (state_q == DRAIN);
    assign request_ack     = i_request_valid && o_request_ready;
    assign response_ack    = resp_q.valid && i_response_ready;
    assign beat_next       = beat_q + BEAT_ONE;
    assign last_beat       = (beat_q == {1'b0, burst_q});

    // A single-flit packet finishes in IDLE before its header fields are captured.
    assign eff_type  = (state_q == IDLE) ? i_request_type     : type_q;
    assign eff_src_x = (state_q == IDLE) ? i_request_source_x : src_x_q;
    assign eff_src_y = (state_q == IDLE) ? i_request_source_y : src_y_q;
    assign eff_tag   = (state_q == IDLE) ? i_request_tag      : tag_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d        = state_q;
        type_d         = type_q;
        src_x_d        = src_x_q;
        src_y_d        = src_y_q;
        tag_d          = tag_q;
        burst_d        = burst_q;
        beat_d         = beat_q;
        resp_d         = resp_q;
        finish_request = 1'b0;

        case (state_q)
            IDLE: begin
                if (request_ack && i_request_head) begin
                    type_d  = i_request_type;
                    src_x_d = i_request_source_x;
                    src_y_d = i_request_source_y;
                    tag_d   = i_request_tag;
                    burst_d = i_request_burst_length;
                    if (i_request_tail) finish_request = 1'b1;
                    else                state_d        = DRAIN;
                end
            end
            DRAIN: begin
                if (request_ack && i_request_tail) finish_request = 1'b1;
            end
            RESPOND: begin
                if (response_ack) begin
                    if (type_q == TYPE_WRITE) begin
                        state_d = IDLE;
                        resp_d  = '0;
                    end else begin
                        state_d     = DATA;
                        beat_d      = '0;
                        resp_d.head = 1'b0;
                        resp_d.tail = (burst_q == '0);
                        resp_d.data = ERROR_DATA;
                    end
                end
            end
            DATA: begin
                if (response_ack) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        resp_d  = '0;
                    end else begin
                        beat_d      = beat_next;
                        resp_d.tail = (beat_next == {1'b0, burst_q});
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish_request) begin
            if ((eff_type == TYPE_READ) || (eff_type == TYPE_WRITE)) begin
                state_d       = RESPOND;
                resp_d.valid  = 1'b1;
                resp_d.head   = 1'b1;
                resp_d.tail   = (eff_type == TYPE_WRITE);
                resp_d.rtype  = (eff_type == TYPE_WRITE);
                resp_d.dst_x  = eff_src_x;
                resp_d.dst_y  = eff_src_y;
                resp_d.src_x  = i_id_x;
                resp_d.src_y  = i_id_y;
                resp_d.tag    = eff_tag;
                resp_d.status = STATUS_DECODE_ERROR;
                resp_d.data   = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            type_q  <= '0;
            src_x_q <= '0;
            src_y_q <= '0;
            tag_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            tag_q   <= tag_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
        end
    end

    assign o_response_valid         = resp_q.valid;
    assign o_response_head          = resp_q.head;
    assign o_response_tail          = resp_q.tail;
    assign o_response_type          = resp_q.rtype;
    assign o_response_destination_x = resp_q.dst_x;
    assign o_response_destination_y = resp_q.dst_y;
    assign o_response_source_x      = resp_q.src_x;
    assign o_response_source_y      = resp_q.src_y;
    assign o_response_tag           = resp_q.tag;
    assign o_response_status        = resp_q.status;
    assign o_response_data          = resp_q.data;

endmodule

// File: tb/tb_tnoc_error_responder.sv
// Self-checking bench for tnoc_error_responder: a packet-level model turns each
// request into its list of expected response flits, compared against a monitor.
module tb_tnoc_error_responder;

    localparam logic [4:0] MY_X = 5'd3;
    localparam logic [4:0] MY_Y = 5'd4;

    typedef struct packed {
        logic         head;
        logic         tail;
        logic         rtype;
        logic [4:0]   dx;
        logic [4:0]   dy;
        logic [4:0]   sx;
        logic [4:0]   sy;
        logic [7:0]   tag;
        logic [1:0]   status;
        logic [255:0] data;
    } flit_t;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_request_valid, o_request_ready;
    logic         i_request_head, i_request_tail;
    logic [1:0]   i_request_type;
    logic [4:0]   i_request_source_x, i_request_source_y;
    logic [7:0]   i_request_tag, i_request_burst_length;
    logic         o_response_valid, i_response_ready;
    logic         o_response_head, o_response_tail, o_response_type;
    logic [4:0]   o_response_destination_x, o_response_destination_y;
    logic [4:0]   o_response_source_x, o_response_source_y;
    logic [7:0]   o_response_tag;
    logic [1:0]   o_response_status;
    logic [255:0] o_response_data;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    flit_t exp_q[$];
    flit_t rx_q[$];
    int    rx_cyc[$];
    logic  rdy_rand   = 1'b0;
    logic  rdy_manual = 1'b1;
    logic  rnd_bit    = 1'b1;
    logic  stall_pend = 1'b0;
    flit_t mon_f, snap;

    tnoc_error_responder dut (
        .i_clk                    (clk),
        .i_rst                    (i_rst),
        .i_id_x                   (MY_X),
        .i_id_y                   (MY_Y),
        .i_request_valid          (i_request_valid),
        .o_request_ready          (o_request_ready),
        .i_request_head           (i_request_head),
        .i_request_tail           (i_request_tail),
        .i_request_type           (i_request_type),
        .i_request_source_x       (i_request_source_x),
        .i_request_source_y       (i_request_source_y),
        .i_request_tag            (i_request_tag),
        .i_request_burst_length   (i_request_burst_length),
        .o_response_valid         (o_response_valid),
        .i_response_ready         (i_response_ready),
        .o_response_head          (o_response_head),
        .o_response_tail          (o_response_tail),
        .o_response_type          (o_response_type),
        .o_response_destination_x (o_response_destination_x),
        .o_response_destination_y (o_response_destination_y),
        .o_response_source_x      (o_response_source_x),
        .o_response_source_y      (o_response_source_y),
        .o_response_tag           (o_response_tag),
        .o_response_status        (o_response_status),
        .o_response_data          (o_response_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 2) != 0);
    end
    assign i_response_ready = rdy_rand ? rnd_bit : rdy_manual;

    function automatic flit_t cur_flit();
        flit_t f;
        f.head   = o_response_head;
        f.tail   = o_response_tail;
        f.rtype  = o_response_type;
        f.dx     = o_response_destination_x;
        f.dy     = o_response_destination_y;
        f.sx     = o_response_source_x;
        f.sy     = o_response_source_y;
        f.tag    = o_response_tag;
        f.status = o_response_status;
        f.data   = o_response_data;
        return f;
    endfunction

    // Collects every handshaken response flit and checks that stalled flits hold.
    always @(negedge clk) begin
        if (i_rst) begin
            stall_pend = 1'b0;
        end else begin
            mon_f = cur_flit();
            if (stall_pend) begin
                checks++;
                if (!o_response_valid || mon_f !== snap) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b flit %h, required valid=1 flit %h",
                             o_response_valid, mon_f, snap);
                end
            end
            if (o_response_valid && i_response_ready) begin
                rx_q.push_back(mon_f);
                rx_cyc.push_back(cyc);
            end
            stall_pend = o_response_valid && !i_response_ready;
            snap       = mon_f;
        end
    end

    // Packet-level reference: what the responder must return for one request packet.
    task automatic expect_packet(input logic [1:0] t, input logic [4:0] sx, input logic [4:0] sy,
                                 input logic [7:0] tag, input logic [7:0] bl);
        flit_t f;
        f.dx = sx; f.dy = sy; f.sx = MY_X; f.sy = MY_Y; f.tag = tag; f.status = 2'b11;
        if (t == 2'b00) begin
            f.head = 1'b1; f.tail = 1'b0; f.rtype = 1'b0; f.data = '0;
            exp_q.push_back(f);
            for (int i = 0; i <= int'(bl); i++) begin
                f.head = 1'b0; f.tail = (i == int'(bl)); f.data = {256{1'b1}};
                exp_q.push_back(f);
            end
        end else if (t == 2'b01) begin
            f.head = 1'b1; f.tail = 1'b1; f.rtype = 1'b1; f.data = '0;
            exp_q.push_back(f);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic send_flit(input logic head, input logic tail, input logic [1:0] t,
                             input logic [4:0] sx, input logic [4:0] sy, input logic [7:0] tag,
                             input logic [7:0] bl, output int acc);
        acc                    = -1;
        i_request_valid        = 1'b1;
        i_request_head         = head;
        i_request_tail         = tail;
        i_request_type         = t;
        i_request_source_x     = sx;
        i_request_source_y     = sy;
        i_request_tag          = tag;
        i_request_burst_length = bl;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (o_request_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            errors++;
            $display("FAIL request_accept: got no ready within 3000 cycles, required acceptance");
            $display("Result: errors=%0d of %0d checks", errors, checks + 1);
            $fatal(1, "request never accepted");
        end
        @(posedge clk);
        #1;
    endtask

    // Head flit plus npay payload flits; payload header fields are garbage and may carry head=1.
    task automatic send_packet(input logic [1:0] t, input logic [4:0] sx, input logic [4:0] sy,
                               input logic [7:0] tag, input logic [7:0] bl, input int npay,
                               input logic pay_heads, output int acc_first, output int acc_last);
        int acc;
        send_flit(1'b1, npay == 0, t, sx, sy, tag, bl, acc);
        acc_first = acc;
        acc_last  = acc;
        for (int p = 0; p < npay; p++) begin
            send_flit(pay_heads && ($urandom_range(0, 3) == 0), p == npay - 1,
                      2'($urandom), 5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), acc);
            acc_last = acc;
        end
        i_request_valid = 1'b0;
        expect_packet(t, sx, sy, tag, bl);
    endtask

    task automatic wait_rx(input int n, input string name);
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            if (rx_q.size() >= n) break;
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() != n) begin
            errors++;
            $display("FAIL %s count: got %0d response flits, required %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_request_valid = 1'b0; i_request_head = 1'b0; i_request_tail = 1'b0;
        i_request_type = '0; i_request_source_x = '0; i_request_source_y = '0;
        i_request_tag = '0; i_request_burst_length = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_request_ready !== 1'b1 || o_response_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got ready=%b valid=%b, required ready=1 valid=0",
                     o_request_ready, o_response_valid);
        end
        checks++;
        if (cur_flit() !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h, required all zero", cur_flit());
        end
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_request_ready !== 1'b1 || o_response_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b, required ready=1 valid=0",
                     o_request_ready, o_response_valid);
        end
    endtask

    task automatic test_read_burst();
        int a0, a1;
        clear_queues();
        rdy_rand = 1'b0; rdy_manual = 1'b1;
        send_packet(2'b00, 5'd1, 5'd2, 8'h5A, 8'd3, 0, 1'b0, a0, a1);
        wait_rx(5, "read_burst");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL read_burst flit %0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
            checks++;
            if (rx_cyc[i] != a1 + 1 + i) begin
                errors++;
                $display("FAIL read_burst timing %0d: got cycle %0d, required %0d", i, rx_cyc[i], a1 + 1 + i);
            end
        end
    endtask

    task automatic test_write_payload();
        int a0, a1;
        clear_queues();
        send_packet(2'b01, 5'd9, 5'd17, 8'h07, 8'd0, 2, 1'b0, a0, a1);
        checks++;
        if (a1 != a0 + 2) begin
            errors++;
            $display("FAIL write_ready: got tail accepted at %0d, required %0d", a1, a0 + 2);
        end
        wait_rx(1, "write_payload");
        if (rx_q.size() > 0) begin
            checks++;
            if (rx_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL write_payload flit: got %h, required %h", rx_q[0], exp_q[0]);
            end
            checks++;
            if (rx_cyc[0] != a1 + 1) begin
                errors++;
                $display("FAIL write_timing: got cycle %0d, required %0d", rx_cyc[0], a1 + 1);
            end
        end
    endtask

    task automatic test_posted_then_read();
        int p0, p1, r0, r1;
        clear_queues();
        send_packet(2'b10, 5'd5, 5'd6, 8'h33, 8'd2, 0, 1'b0, p0, p1);
        send_packet(2'b00, 5'd7, 5'd8, 8'hC4, 8'd1, 0, 1'b0, r0, r1);
        checks++;
        if (r0 != p1 + 1) begin
            errors++;
            $display("FAIL posted_ready: got read accepted at %0d, required %0d", r0, p1 + 1);
        end
        wait_rx(3, "posted_then_read");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL posted_then_read flit %0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int a0, a1;
        logic seen;
        clear_queues();
        rdy_manual = 1'b0;
        send_packet(2'b00, 5'($urandom), 5'($urandom), 8'($urandom), 8'd1, 1, 1'b0, a0, a1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = o_response_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_header: got no valid within 20 cycles, required header");
        end
        repeat (2) @(negedge clk);
        checks++;
        if (o_request_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_ready: got %b while responding, required 0", o_request_ready);
        end
        @(posedge clk); #1; rdy_manual = 1'b1;
        @(posedge clk); #1; rdy_manual = 1'b0;
        repeat (2) @(posedge clk);
        #1; rdy_manual = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_request_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_final_ready: got %b on final handshake cycle, required 0", o_request_ready);
        end
        @(negedge clk);
        checks++;
        if (o_request_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_return_ready: got %b after final handshake, required 1", o_request_ready);
        end
        wait_rx(3, "stall");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall flit %0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0, a1, o0, o1;
        clear_queues();
        rdy_manual = 1'b1;
        send_packet(2'b00, 5'd11, 5'd12, 8'h99, 8'd7, 0, 1'b0, a0, a1);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (rx_q.size() >= 3) break;
        end
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_response_valid !== 1'b0 || o_request_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b ready=%b, required valid=0 ready=1",
                     o_response_valid, o_request_ready);
        end
        clear_queues();
        send_flit(1'b0, 1'b0, 2'b00, 5'd1, 5'd1, 8'h01, 8'h10, o0);
        send_flit(1'b0, 1'b1, 2'b01, 5'd2, 5'd2, 8'h02, 8'h20, o1);
        i_request_valid = 1'b0;
        checks++;
        if (o1 != o0 + 1) begin
            errors++;
            $display("FAIL orphan_accept: got second orphan at %0d, required %0d", o1, o0 + 1);
        end
        send_packet(2'b01, 5'd13, 5'd14, 8'hE1, 8'd0, 1, 1'b0, a0, a1);
        wait_rx(1, "reset_mid_write");
        if (rx_q.size() > 0) begin
            checks++;
            if (rx_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL reset_mid_write flit: got %h, required %h", rx_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_max_burst();
        int a0, a1;
        clear_queues();
        rdy_manual = 1'b1;
        send_packet(2'b00, 5'd30, 5'd31, 8'hFF, 8'hFF, 0, 1'b0, a0, a1);
        wait_rx(257, "max_burst");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL max_burst flit %0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
        end
        if (rx_cyc.size() == 257) begin
            checks++;
            if (rx_cyc[256] != a1 + 257) begin
                errors++;
                $display("FAIL max_burst timing: got last at %0d, required %0d", rx_cyc[256], a1 + 257);
            end
        end
    endtask

    task automatic test_random();
        int a0, a1, o;
        clear_queues();
        rdy_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_flit(1'b0, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                          8'($urandom), 8'($urandom), o);
                i_request_valid = 1'b0;
            end
            send_packet(2'($urandom), 5'($urandom), 5'($urandom), 8'($urandom),
                        8'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b1, a0, a1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_rx(exp_q.size(), "random");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random flit %0d: got %h, required %h", i, rx_q[i], exp_q[i]);
            end
        end
        rdy_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_payload();
        test_posted_then_read();
        test_stall();
        test_reset_mid();
        test_max_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tnoc_error_responder.md
Name: tnoc_error_responder

Overview:
- Default-target endpoint of the NoC. Consumes request packets whose address decodes to no slave and returns error response packets.
- Read requests get a header plus burst data flits filled with ERROR_DATA, status DECODE_ERROR.
- Write requests get a single-flit write response with status DECODE_ERROR. Posted writes are drained with no response.
- Sits behind the local port of the router that hosts the default target.

Parameters:
- ID_X_WIDTH, 5, width of X node id.
- ID_Y_WIDTH, 5, width of Y node id.
- TAG_WIDTH, 8, width of request/response tag.
- BURST_LENGTH_WIDTH, 8, width of burst length field; a field value n means n+1 beats.
- DATA_WIDTH, 256, width of the response data flit.
- ERROR_DATA, all ones (DATA_WIDTH bits), data returned on every read beat.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_id_x  input  ID_X_WIDTH  own node X id, static
- i_id_y  input  ID_Y_WIDTH  own node Y id, static
- i_request_valid  input  1  request flit valid
- o_request_ready  output  1  request flit accepted when valid&ready
- i_request_head  input  1  flit is packet header
- i_request_tail  input  1  flit is last of packet
- i_request_type  input  2  header only: 00 read, 01 write, 10 posted write, 11 reserved
- i_request_source_x  input  ID_X_WIDTH  header only: requester X
- i_request_source_y  input  ID_Y_WIDTH  header only: requester Y
- i_request_tag  input  TAG_WIDTH  header only: tag
- i_request_burst_length  input  BURST_LENGTH_WIDTH  header only: beats-1
- o_response_valid  output  1  response flit valid
- i_response_ready  input  1  downstream accepts response flit
- o_response_head  output  1  response header flit
- o_response_tail  output  1  last response flit
- o_response_type  output  1  0 read response, 1 write response
- o_response_destination_x  output  ID_X_WIDTH  = captured source_x
- o_response_destination_y  output  ID_Y_WIDTH  = captured source_y
- o_response_source_x  output  ID_X_WIDTH  = i_id_x
- o_response_source_y  output  ID_Y_WIDTH  = i_id_y
- o_response_tag  output  TAG_WIDTH  = captured tag
- o_response_status  output  2  fixed 2'b11 (DECODE_ERROR) on every response flit
- o_response_data  output  DATA_WIDTH  ERROR_DATA on read data flits, 0 otherwise

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: state IDLE, o_request_ready=1, o_response_valid=0, all other response outputs 0, beat counter 0.
- State IDLE: o_request_ready=1.
  - Head flit accepted: capture type, source, tag, burst_length.
  - If head&tail: go to RESPOND, or back to IDLE for posted/reserved.
  - Head without tail: go to DRAIN.
  - Non-head flit accepted in IDLE (orphan): discarded, stay IDLE.
- State DRAIN: o_request_ready=1. Accept and discard flits until tail. On tail: RESPOND (read/write) or IDLE (posted/reserved). A head flit seen in DRAIN is treated as payload, with no re-capture.
- State RESPOND: o_request_ready=0.
  - Header flit: o_response_valid=1 first cycle after the tail handshake, head=1.
  - Write: tail=1 on the header; done when the handshake completes.
  - Read: tail=0 on the header, then DATA.
- State DATA: o_request_ready=0. burst_length+1 flits, head=0, data=ERROR_DATA. Tail=1 on final beat. Beat counter is BURST_LENGTH_WIDTH+1 bits; max burst (all ones) yields 2^BURST_LENGTH_WIDTH beats with no wrap.
- Response outputs: registered. All fields are held stable while valid&!ready. The next flit is presented the cycle after the handshake; back-to-back flits are allowed (one per cycle with ready=1).
- Return to IDLE: after the final response handshake, the state goes IDLE and o_request_ready=1 next cycle. The next request is not accepted in the same cycle as the final response handshake.
- Latency: tail accepted at cycle t -> response header valid at t+1. Full read with continuous ready: last data flit at t+1+(burst_length+1).
- Reset mid-operation: any state -> IDLE, response valid dropped immediately. Remaining flits of an interrupted packet arrive as non-head and are discarded as orphans.
- Reserved type: drained like posted, no response.

Test Plan:
- Read, burst_length=3, src (1,2), tag 0x5A, ready=1 -> header (type 0, dest (1,2), tag 0x5A, status 2'b11) then 4 data flits of all-ones, tail on 4th, all on consecutive cycles starting t+1.
- Write head + 2 payload flits, tail on 3rd, tag 0x07 -> request ready through all 3; one flit head=1, tail=1, type 1, tag 0x07, at t+1; no further flits.
- Posted write, single flit head&tail -> no response valid ever; ready stays 1; next read is accepted the following cycle.
- Read burst_length=1 with i_response_ready low for 3 cycles on the header and 2 on beat 1 -> fields stable while stalled; exactly 2 data flits; o_request_ready=0 until the final handshake +1.
- Reset asserted during DATA beat 2 of burst_length=7 -> valid=0 the cycle after reset; 2 leftover non-head flits are accepted and discarded; following write gets a correct single response.
- burst_length=8'hFF read -> exactly 256 data flits, tail only on the 256th.
